// File: rtl/sdr_tune_pkg.sv
// sdr_tune_pkg: shared types and constants for the SDR retune sequencer and its CSR glue
package sdr_tune_pkg;

    localparam logic [63:0] DEF_PHASE_INC = 64'h25BA5E353F7CED91;
    localparam logic [3:0]  DEF_SHIFT     = 4'd2;
    localparam logic [3:0]  DEF_MUTE      = 4'd15;
    localparam int unsigned DEF_SETTLE    = 64;

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        RETUNE,
        SETTLE,
        FADE_IN
    } tune_state_e;

    typedef struct packed {
        logic [63:0] phase_inc;
        logic        lsb;
        logic [3:0]  shift;
    } tune_cfg_t;

    // One saturating step of an attenuation shift toward a goal, in either direction
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] goal);
        return (cur < goal) ? cur + 4'd1 : (cur > goal) ? cur - 4'd1 : cur;
    endfunction

endpackage

// File: rtl/sdr_tune_ctrl.sv
// sdr_tune_ctrl: click-free retune sequencer (fade-out, retune, settle, fade-in) on decimated-sample boundaries
//   clk, rst_n                         clock, async active-low reset
//   cfg_we, cfg_phase_inc, cfg_lsb,
//   cfg_shift                          config write into the one-entry pending buffer
//   cfg_clr                            clears the sticky overrun flag
//   sample_stb                         decimated-sample strobe; all fade/settle steps advance on it
//   phase_inc_o, lsb_rx_o              LO phase increment and sideband applied to the receive chain
//   audio_shift_o                      audio attenuation shift (15 = muted)
//   busy, retune_stb, overrun          status
module sdr_tune_ctrl
    import sdr_tune_pkg::*;
#(
    parameter logic [63:0] RESET_PHASE_INC = DEF_PHASE_INC,
    parameter logic [3:0]  RESET_SHIFT     = DEF_SHIFT,
    parameter int unsigned SETTLE_SAMPLES  = DEF_SETTLE,
    parameter logic [3:0]  MUTE_SHIFT      = DEF_MUTE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [63:0] cfg_phase_inc,
    input  logic        cfg_lsb,
    input  logic [3:0]  cfg_shift,
    input  logic        cfg_clr,
    input  logic        sample_stb,
    output logic [63:0] phase_inc_o,
    output logic        lsb_rx_o,
    output logic [3:0]  audio_shift_o,
    output logic        busy,
    output logic        retune_stb,
    output logic        overrun
);

    tune_state_e state, state_next;
    tune_cfg_t   pend;
    logic        pending, retune_req, consume;
    logic [3:0]  target, shift_next;
    logic [15:0] count;

    assign retune_req = pending && (pend.phase_inc != phase_inc_o || pend.lsb != lsb_rx_o);
    assign busy       = state != IDLE || pending;

    // consume: the pending entry is taken this cycle and its shift becomes the new target
    always_comb begin
        state_next = state;
        consume    = 1'b0;
        shift_next = audio_shift_o;
        case (state)
            IDLE: begin
                if (sample_stb && pending) begin
                    if (retune_req) begin
                        state_next = FADE_OUT;
                    end else begin
                        consume    = 1'b1;
                        state_next = (pend.shift != audio_shift_o) ? FADE_IN : IDLE;
                    end
                end
            end
            FADE_OUT: begin
                if (audio_shift_o == MUTE_SHIFT)
                    state_next = RETUNE;
                else if (sample_stb)
                    shift_next = step_toward(audio_shift_o, MUTE_SHIFT);
            end
            RETUNE: begin
                consume    = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                // Already muted, so a new retune skips straight back to RETUNE
                if (retune_req) begin
                    state_next = RETUNE;
                end else begin
                    consume = pending;
                    if (sample_stb && count <= 16'd1)
                        state_next = FADE_IN;
                end
            end
            FADE_IN: begin
                if (retune_req)
                    state_next = FADE_OUT;
                else if (pending)
                    consume = 1'b1;
                else if (audio_shift_o == target)
                    state_next = IDLE;
                else if (sample_stb)
                    shift_next = step_toward(audio_shift_o, target);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SETTLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_inc_o   <= RESET_PHASE_INC;
            lsb_rx_o      <= 1'b0;
            audio_shift_o <= MUTE_SHIFT;
            target        <= RESET_SHIFT;
            pend          <= '0;
            pending       <= 1'b0;
            overrun       <= 1'b0;
            retune_stb    <= 1'b0;
            count         <= 16'(SETTLE_SAMPLES);
        end else begin
            retune_stb    <= state == RETUNE;
            audio_shift_o <= shift_next;
            if (state == RETUNE) begin
                phase_inc_o <= pend.phase_inc;
                lsb_rx_o    <= pend.lsb;
                count       <= 16'(SETTLE_SAMPLES);
            end else if (state == SETTLE && sample_stb && !retune_req) begin
                count <= count - 16'd1;
            end
            if (consume)
                target <= pend.shift;
            // A write in the same cycle as a consume is kept, so it wins over the clear
            if (cfg_we) begin
                pend    <= '{phase_inc: cfg_phase_inc, lsb: cfg_lsb, shift: cfg_shift};
                pending <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end
            if (cfg_we && pending)
                overrun <= 1'b1;
            else if (cfg_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: doc/sdr_tune_ctrl.md
Name: sdr_tune_ctrl

Overview:
Sequences retuning of the SDR receive chain: DDS LO phase increment, USB/LSB select and audio attenuation shift.
- Accepts CSR configuration writes at any time.
- Applies them only on decimated-sample boundaries (CIC out_valid), as a click-free fade-out / retune / settle / fade-in sequence.
- Sits between the LiteX CSR bank and the DDS_lo, audio-combine and pt8211 paths inside the SDR peripheral.

Parameters:
RESET_PHASE_INC, 64'h25BA5E353F7CED91, phase increment after reset (7074 kHz at 48 MHz)
RESET_SHIFT, 4'd2, target audio attenuation shift after reset
SETTLE_SAMPLES, 64, sample strobes to wait after a retune (CIC + Hilbert flush); range 1..65535
MUTE_SHIFT, 4'd15, attenuation shift treated as muted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  one-cycle config write strobe
cfg_phase_inc  in  64  requested LO phase increment
cfg_lsb  in  1  requested sideband, 1 = LSB
cfg_shift  in  4  requested audio attenuation shift
cfg_clr  in  1  clears overrun flag
sample_stb  in  1  decimated-sample strobe (CIC out_valid), one clk wide
phase_inc_o  out  64  phase increment to DDS
lsb_rx_o  out  1  sideband select to audio combiner
audio_shift_o  out  4  arithmetic right-shift for audio_out
busy  out  1  high whenever state != IDLE or pending set
retune_stb  out  1  one-clk pulse in the cycle phase_inc_o changes
overrun  out  1  sticky: a pending request was overwritten

Behaviour:
Reset (async, rst_n low):
- phase_inc_o = RESET_PHASE_INC; lsb_rx_o = 0; audio_shift_o = MUTE_SHIFT.
- target = RESET_SHIFT; pending = 0; overrun = 0; retune_stb = 0.
- State = SETTLE, counter = SETTLE_SAMPLES. Power-up therefore settles, then fades in.

Pending buffer (one entry):
- cfg_we latches {phase, lsb, shift} and sets pending; the newest write wins.
- cfg_we while pending is already set also sets overrun. Same-cycle consume and write: the write is kept and pending stays set.
- cfg_clr clears overrun. If cfg_clr and the overrun-setting event coincide, set wins.
- A retune request is a pending entry whose phase != phase_inc_o or lsb != lsb_rx_o. Otherwise the entry is volume-only.

FSM. All fade/settle steps advance only on sample_stb. RETUNE is a single clk.
- IDLE:
  - sample_stb with a pending retune -> FADE_OUT.
  - sample_stb with pending volume-only -> target = shift, clear pending, -> FADE_IN if target != audio_shift_o, else stay in IDLE.
- FADE_OUT: each sample_stb, audio_shift_o += 1. When audio_shift_o == MUTE_SHIFT (including on entry) -> RETUNE, without waiting for another strobe.
- RETUNE:
  - phase_inc_o, lsb_rx_o <= pending values; target <= pending shift; clear pending.
  - retune_stb = 1 this cycle; counter = SETTLE_SAMPLES; -> SETTLE.
- SETTLE:
  - Each sample_stb decrements the counter.
  - A pending retune -> RETUNE immediately (already muted); the settle count restarts.
  - Pending volume-only: target updated, pending cleared, settle continues.
  - Counter reaches 0 -> FADE_IN.
- FADE_IN:
  - Each sample_stb, audio_shift_o steps one toward target, either direction.
  - Equal to target -> IDLE.
  - A pending retune -> FADE_OUT from the current shift.
  - Pending volume-only: target updated, pending cleared.

Timing and widths:
- Outputs are registered. retune_stb occurs exactly one clk after the condition that enters RETUNE.
- phase_inc_o changes only in RETUNE. audio_shift_o changes by at most 1 per sample_stb.
- Counter is 16 bits. Shift arithmetic is saturating in 0..15.
- rst_n assertion mid-sequence aborts the sequence and restores reset values immediately.

Decomposition:
sdr_tune_pkg holds:
- State enum {IDLE, FADE_OUT, RETUNE, SETTLE, FADE_IN}.
- MUTE_SHIFT and the default phase-increment constant.
- Config struct {phase_inc[63:0], lsb, shift[3:0]} shared with the CSR glue.

No sub-module. The one-entry pending buffer and the FSM stay in a single module of about 200 lines.

Test Plan:
1. Reset, sample_stb every 256 clk -> audio_shift_o=15 for 64 strobes, then steps 15→2 over 13 strobes; busy drops; phase_inc_o=25BA5E353F7CED91 throughout.
2. In IDLE at shift 2, write phase=1C4CCCCCCCCCCCCC -> 13 strobes fading to 15, then retune_stb one clk later with phase_inc_o updated; 64-strobe settle; 13-strobe fade-in back to 2.
3. Write the same phase with shift=5 -> no retune_stb; shift steps 2→3→4→5 on three strobes.
4. During SETTLE (counter=10), write a new phase -> RETUNE next clk, second retune_stb, full 64-strobe settle restarts, audio_shift_o stays 15.
5. Two cfg_we before any strobe while in IDLE -> overrun=1, second value applied; cfg_clr -> overrun=0.
6. rst_n low during FADE_IN at shift 8 -> outputs return to reset values immediately; the sequence restarts from SETTLE.
